// File: rtl/pc_gen_pkg.sv
// Shared core definitions for the program-counter generator: FSM state
// encoding and the default boot address.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h8000_0000;

endpackage

// File: rtl/pc_gen_pc_reg.sv
// Program-counter storage: an XLEN-bit register with load enable that
// returns to RESET_VEC on asynchronous reset.
module pc_reg
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VEC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Instruction-fetch PC generator: sequencing FSM, trap/redirect target
// selection, misalignment trapping and debug halt.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEFAULT_RESET_VEC),
  parameter int              ILEN_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            halt_req,
  output logic            halted,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr,
  input  logic            err_ack
);

  localparam logic [XLEN-1:0] INC        = XLEN'(ILEN_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);

  pc_state_t       state;
  pc_state_t       state_next;
  logic            boot_done;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] target;
  logic            pc_load;
  logic            target_sel;
  logic            target_bad;
  logic            handshake;
  logic            misalign_event;

  pc_reg #(
    .XLEN      (XLEN),
    .RESET_VEC (RESET_VEC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .d    (pc_next),
    .q    (pc)
  );

  assign fetch_pc       = pc;
  assign fetch_valid    = (state == RUN) && !stall;
  assign handshake      = fetch_valid && fetch_ready;
  assign misalign_event = target_sel && target_bad;

  // Trap beats redirect beats sequential; in ERROR only an aligned trap
  // can restart fetching.
  always_comb begin
    target     = trap_valid ? trap_pc : redirect_pc;
    target_bad = |(target & ALIGN_MASK);
    target_sel = 1'b0;
    pc_next    = pc + INC;
    pc_load    = 1'b0;
    state_next = state;
    case (state)
      BOOT: begin
        if (boot_done) state_next = RUN;
      end
      RUN, HALTED: begin
        target_sel = trap_valid || redirect_valid;
        if (target_sel && target_bad) begin
          state_next = ERROR;
        end else begin
          if (target_sel) begin
            pc_next = target;
            pc_load = 1'b1;
          end else if (handshake) begin
            pc_load = 1'b1;
          end
          state_next = halt_req ? HALTED : RUN;
        end
      end
      ERROR: begin
        target_sel = trap_valid;
        if (target_sel && !target_bad) begin
          pc_next    = target;
          pc_load    = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  // BOOT spans one full cycle after reset release so the first fetch
  // appears two edges after rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= BOOT;
      boot_done     <= 1'b0;
      halted        <= 1'b0;
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      state     <= state_next;
      boot_done <= 1'b1;
      halted    <= (state_next == HALTED);
      if (misalign_event) begin
        misalign_err  <= 1'b1;
        misalign_addr <= target;
      end else if (err_ack) begin
        misalign_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with hand-computed expectations.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        halt_req;
  logic        halted;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic        misalign_err;
  logic [31:0] misalign_addr;
  logic        err_ack;

  int assertions = 0;
  int failures   = 0;

  pc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .halt_req       (halt_req),
    .halted         (halted),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
    .misalign_err   (misalign_err),
    .misalign_addr  (misalign_addr),
    .err_ack        (err_ack)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    assertions++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    trap_valid = 1'b0; trap_pc = '0; halt_req = 1'b0; fetch_ready = 1'b0;
    err_ack = 1'b0;

    #12;
    check_output("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check_output("rst_halted", 32'(halted), 32'd0);
    check_output("rst_misalign_err", 32'(misalign_err), 32'd0);
    check_output("rst_misalign_addr", misalign_addr, 32'h0);
    check_output("rst_fetch_pc", fetch_pc, 32'h8000_0000);

    // Reset release: one edge still in BOOT, the second enters RUN.
    rst = 1'b0;
    fetch_ready = 1'b1;
    step();
    check_output("boot_no_fetch", 32'(fetch_valid), 32'd0);
    step();
    check_output("first_fetch_valid", 32'(fetch_valid), 32'd1);
    check_output("first_fetch_pc", fetch_pc, 32'h8000_0000);
    step();
    check_output("seq_pc_4", fetch_pc, 32'h8000_0004);
    step();
    check_output("seq_pc_8", fetch_pc, 32'h8000_0008);

    // Unaccepted request stays put, then is cancelled by trap over redirect.
    fetch_ready = 1'b0;
    step();
    check_output("stable_unaccepted", fetch_pc, 32'h8000_0008);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    trap_valid = 1'b1; trap_pc = 32'h200;
    step();
    check_output("trap_beats_redirect", fetch_pc, 32'h200);
    check_output("trap_fetch_valid", 32'(fetch_valid), 32'd1);
    trap_valid = 1'b0;
    step();
    check_output("redirect_alone", fetch_pc, 32'h100);
    redirect_valid = 1'b0;

    // Misaligned redirect.
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    check_output("mis_err_set", 32'(misalign_err), 32'd1);
    check_output("mis_addr", misalign_addr, 32'h102);
    check_output("mis_no_fetch", 32'(fetch_valid), 32'd0);
    check_output("mis_pc_held", fetch_pc, 32'h100);
    step();
    check_output("mis_err_sticky", 32'(misalign_err), 32'd1);
    err_ack = 1'b1;
    step();
    err_ack = 1'b0;
    check_output("mis_err_acked", 32'(misalign_err), 32'd0);
    check_output("err_still_idle", 32'(fetch_valid), 32'd0);
    trap_valid = 1'b1; trap_pc = 32'h300;
    step();
    trap_valid = 1'b0;
    check_output("err_trap_pc", fetch_pc, 32'h300);
    check_output("err_trap_run", 32'(fetch_valid), 32'd1);

    // Stall and wrap-around.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check_output("wrap_setup", fetch_pc, 32'hFFFF_FFFC);
    stall = 1'b1; fetch_ready = 1'b1;
    #1;
    check_output("stall_drops_valid", 32'(fetch_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("stall_pc_hold", fetch_pc, 32'hFFFF_FFFC);
      check_output("stall_no_fetch", 32'(fetch_valid), 32'd0);
    end
    stall = 1'b0;
    #1;
    check_output("unstall_valid", 32'(fetch_valid), 32'd1);
    step();
    check_output("wrap_to_zero", fetch_pc, 32'h0);
    fetch_ready = 1'b0;

    // Halt during a handshake at 0x80.
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    check_output("halt_setup", fetch_pc, 32'h80);
    halt_req = 1'b1; fetch_ready = 1'b1;
    step();
    check_output("halted_set", 32'(halted), 32'd1);
    check_output("halted_no_fetch", 32'(fetch_valid), 32'd0);
    check_output("halted_pc", fetch_pc, 32'h84);
    step();
    check_output("halted_pc_hold", fetch_pc, 32'h84);
    halt_req = 1'b0;
    step();
    check_output("resume_halted_clr", 32'(halted), 32'd0);
    check_output("resume_valid", 32'(fetch_valid), 32'd1);
    check_output("resume_pc", fetch_pc, 32'h84);
    fetch_ready = 1'b0;

    // Trap together with halt request.
    trap_valid = 1'b1; trap_pc = 32'h400; halt_req = 1'b1;
    step();
    trap_valid = 1'b0;
    check_output("trap_halt_halted", 32'(halted), 32'd1);
    check_output("trap_halt_pc", fetch_pc, 32'h400);
    halt_req = 1'b0;
    step();
    check_output("trap_halt_resume", fetch_pc, 32'h400);
    check_output("trap_halt_valid", 32'(fetch_valid), 32'd1);

    // Misaligned error recovered by trap before ack leaves the flag set.
    redirect_valid = 1'b1; redirect_pc = 32'h206;
    step();
    redirect_valid = 1'b0;
    trap_valid = 1'b1; trap_pc = 32'h500;
    step();
    trap_valid = 1'b0;
    check_output("recover_pc", fetch_pc, 32'h500);
    check_output("recover_err_kept", 32'(misalign_err), 32'd1);
    check_output("recover_valid", 32'(fetch_valid), 32'd1);

    // Asynchronous reset mid-request.
    #2;
    rst = 1'b1;
    #1;
    check_output("async_valid_drop", 32'(fetch_valid), 32'd0);
    check_output("async_pc", fetch_pc, 32'h8000_0000);
    check_output("async_err_clr", 32'(misalign_err), 32'd0);
    check_output("async_addr_clr", misalign_addr, 32'h0);
    step();
    rst = 1'b0;
    step();
    check_output("reboot_idle", 32'(fetch_valid), 32'd0);
    step();
    check_output("reboot_valid", 32'(fetch_valid), 32'd1);
    check_output("reboot_pc", fetch_pc, 32'h8000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL take parameter XLEN, default 32, as the address width in bits.
REQ-002 SHALL take parameter RESET_VEC, default 32'h8000_0000, as the first fetch address after reset.
REQ-003 SHALL take parameter ILEN_BYTES, default 4, as the sequential increment; it must be a power of two.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port stall, input, 1 bit: freezes sequential advance.
REQ-007 SHALL have ports redirect_valid (input, 1) and redirect_pc (input, XLEN): branch or jump target.
REQ-008 SHALL have ports trap_valid (input, 1) and trap_pc (input, XLEN): trap or return target.
REQ-009 SHALL have ports halt_req (input, 1) and halted (output, 1): debug halt request and halt status.
REQ-010 SHALL have ports fetch_valid (output, 1), fetch_ready (input, 1) and fetch_pc (output, XLEN): the fetch request handshake.
REQ-011 SHALL have ports misalign_err (output, 1), misalign_addr (output, XLEN) and err_ack (input, 1): misaligned-target report.

Function
REQ-012 SHALL implement FSM states BOOT, RUN, HALTED and ERROR.
REQ-013 BOOT SHALL hold fetch_valid=0 and SHALL move to RUN unconditionally on the next cycle.
REQ-014 RUN SHALL assert fetch_valid=1 whenever stall=0, with fetch_pc equal to the current pc register.
REQ-015 A fetch handshake (fetch_valid && fetch_ready) with no redirect or trap SHALL set pc <= pc + ILEN_BYTES, modulo 2^XLEN (wrap-around, no flag).
REQ-016 With stall=1, fetch_valid SHALL be 0 and pc SHALL hold, unless trap_valid or redirect_valid is asserted.
REQ-017 Target priority SHALL be: trap_valid > redirect_valid > sequential.
- A trap or redirect SHALL load pc in the same cycle regardless of stall or fetch_ready.
- Both SHALL apply in RUN and HALTED.
REQ-018 An unaccepted request (fetch_valid=1, fetch_ready=0) SHALL be cancellable: a trap or redirect replaces fetch_pc from the next cycle.
- Without a trap or redirect, fetch_pc SHALL stay stable until accepted.
REQ-019 A selected target with any bit in [log2(ILEN_BYTES)-1:0] set SHALL NOT load pc.
- The FSM SHALL enter ERROR.
- misalign_addr SHALL capture the target.
- misalign_err SHALL be 1 from the next cycle.
REQ-020 ERROR SHALL hold fetch_valid=0 and hold pc.
- A valid, aligned trap_pc in ERROR SHALL load pc and return to RUN; misalign_err SHALL stay set until acknowledged.
- err_ack=1 SHALL clear misalign_err on the next cycle.
REQ-021 halt_req=1 in RUN SHALL move the FSM to HALTED after any handshake in that cycle completes.
- HALTED SHALL hold fetch_valid=0 and set halted=1 from the next cycle.
REQ-022 halt_req=0 in HALTED SHALL return the FSM to RUN on the next cycle, resuming at pc.
REQ-023 A trap and halt_req in the same cycle SHALL apply the trap to pc and then halt; resume SHALL fetch trap_pc.

Reset
REQ-024 Asserting rst SHALL immediately force:
- pc=RESET_VEC and state=BOOT;
- fetch_valid=0, halted=0, misalign_err=0, misalign_addr=0.
REQ-025 Reset asserted mid-request SHALL drop fetch_valid with no handshake completing.
REQ-026 The first fetch_valid after reset release SHALL occur exactly 2 rising edges later, with fetch_pc=RESET_VEC.

Structure
REQ-027 The state enum pc_state_t and the default RESET_VEC constant SHALL live in the shared core package.
REQ-028 The pc register SHALL be a sub-module, pc_reg, parametrised by XLEN and RESET_VEC, with a load enable.
REQ-029 Next-PC selection and the FSM SHALL live in pc_gen.

Verification
REQ-030 Reset test: release rst -> BOOT for 1 cycle; fetch_pc=32'h8000_0000 with fetch_valid=1 on cycle 2; fetch_ready held 1 -> fetch_pc 0x8000_0004, then 0x8000_0008.
REQ-031 Priority and cancel test: fetch_ready=0 with redirect_pc=0x100 and trap_pc=0x200 in the same cycle -> next fetch_pc=0x200; redirect alone -> 0x100.
REQ-032 Misalignment test: redirect_pc=0x102 -> misalign_err=1, misalign_addr=0x102, fetch_valid=0, pc unchanged; err_ack -> flag clears; trap_pc=0x300 -> RUN at 0x300.
REQ-033 Stall and wrap test: pc=0xFFFF_FFFC; stall 3 cycles -> pc holds, fetch_valid=0; release with a handshake -> fetch_pc 0x0000_0000.
REQ-034 Halt test: halt_req during a handshake at 0x80 -> halted=1 and the next pc=0x84 is held; drop halt_req -> fetch resumes at 0x84.
REQ-035 Async reset test: assert rst between clock edges while fetch_valid=1 -> fetch_valid falls before the next edge and pc=RESET_VEC.
